// File: rtl/polynomial3_coeff_loader.sv
// Collects a, b, c coefficient beats from a narrow stream and presents them as one
// packed {a, b, c} set on a valid/ready source, counting framing errors on the way.
module polynomial3_coeff_loader #(
    parameter int COEFF_W = 24,
    parameter int ERR_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [COEFF_W-1:0]   in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3*COEFF_W-1:0] out_data,
    output logic                 frame_err,
    output logic [ERR_W-1:0]     err_count
);

    typedef enum logic [1:0] {
        WAIT_A,
        WAIT_B,
        WAIT_C,
        DISCARD
    } state_t;

    state_t                 state_q;
    logic [COEFF_W-1:0]     a_q;
    logic [COEFF_W-1:0]     b_q;
    logic [3*COEFF_W-1:0]   out_data_q;
    logic                   out_valid_q;
    logic                   frame_err_q;
    logic [ERR_W-1:0]       err_count_q;

    logic                   accept_beat;
    logic                   frame_err_d;

    // The c beat is the only one that can stall: it needs the output slot free or freeing.
    assign in_ready = !rst && ((state_q != WAIT_C) || !out_valid_q || out_ready);

    assign accept_beat = in_valid && in_ready;

    always_comb begin
        frame_err_d = 1'b0;
        if (accept_beat) begin
            case (state_q)
                WAIT_A:  frame_err_d = in_last;
                WAIT_B:  frame_err_d = in_last;
                WAIT_C:  frame_err_d = !in_last;
                default: frame_err_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT_A;
            a_q         <= '0;
            b_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            frame_err_q <= frame_err_d;

            if (frame_err_d && (err_count_q != {ERR_W{1'b1}})) begin
                err_count_q <= err_count_q + ERR_W'(1);
            end

            // A reload below overrides this clear when handshake and reload coincide.
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (accept_beat) begin
                case (state_q)
                    WAIT_A: begin
                        if (!in_last) begin
                            a_q     <= in_data;
                            state_q <= WAIT_B;
                        end
                    end
                    WAIT_B: begin
                        if (in_last) begin
                            state_q <= WAIT_A;
                        end else begin
                            b_q     <= in_data;
                            state_q <= WAIT_C;
                        end
                    end
                    WAIT_C: begin
                        if (in_last) begin
                            out_data_q  <= {a_q, b_q, in_data};
                            out_valid_q <= 1'b1;
                            state_q     <= WAIT_A;
                        end else begin
                            state_q <= DISCARD;
                        end
                    end
                    DISCARD: begin
                        if (in_last) begin
                            state_q <= WAIT_A;
                        end
                    end
                    default: state_q <= WAIT_A;
                endcase
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign frame_err = frame_err_q;
    assign err_count = err_count_q;

endmodule
